// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcodes, FSM states and
// iteration count for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int MDU_ITER  = 32;
  localparam int MDU_CNT_W = $clog2(MDU_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: command (start/op/a/b) from control,
// status and HI/LO (busy/done/hi/lo) back from the MDU.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational conditional negate.
// Ports: val in, neg in, res = neg ? -val : val.
module mdu_sign_fix #(
  parameter int W = 64
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative MULT/MULTU/DIV/DIVU + MTHI/MTLO.
// Ports: clk, reset (sync, high), bus (slave modport).
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  mdu_hilo_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;
  logic                 asgn_q, asgn_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic is_md, is_sgn, is_div;
  logic is_mthi, is_mtlo;

  assign is_md   = bus.op <= MDU_DIVU;
  assign is_sgn  = (bus.op == MDU_MULT) ||
                   (bus.op == MDU_DIV);
  assign is_div  = (bus.op == MDU_DIV) ||
                   (bus.op == MDU_DIVU);
  assign is_mthi = bus.op == MDU_MTHI;
  assign is_mtlo = bus.op == MDU_MTLO;

  logic [WIDTH-1:0] a_mag, b_mag;

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (
    .val (bus.a),
    .neg (is_sgn & bus.a[WIDTH-1]),
    .res (a_mag)
  );

  mdu_sign_fix #(.W(WIDTH)) u_abs_b (
    .val (bus.b),
    .neg (is_sgn & bus.b[WIDTH-1]),
    .res (b_mag)
  );

  // multiply: add multiplicand into the upper half
  // when the current LSB is set, then shift right
  logic [WIDTH:0] add_sum;

  assign add_sum = {1'b0, prod_q[PW-1:WIDTH]} +
                   (prod_q[0] ? {1'b0, mcand_q}
                              : '0);

  // divide: prod_q[WIDTH-1:0] shifts the dividend
  // out at the top and the quotient in at the bottom
  logic [WIDTH+1:0] rem_sh, trial;
  logic             q_bit;

  assign rem_sh = {rem_q, prod_q[WIDTH-1]};
  assign trial  = rem_sh - {2'b00, mcand_q};
  assign q_bit  = ~trial[WIDTH+1];

  logic [PW-1:0]    p_fix;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             div0;

  // a zero divisor leaves the all-ones quotient
  // uncorrected, whatever the operand signs
  assign div0 = mcand_q == '0;

  mdu_sign_fix #(.W(PW)) u_fix_p (
    .val (prod_q),
    .neg (neg_q),
    .res (p_fix)
  );

  mdu_sign_fix #(.W(WIDTH)) u_fix_q (
    .val (prod_q[WIDTH-1:0]),
    .neg (neg_q & ~div0),
    .res (q_fix)
  );

  mdu_sign_fix #(.W(WIDTH)) u_fix_r (
    .val (rem_q[WIDTH-1:0]),
    .neg (asgn_q),
    .res (r_fix)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    asgn_d  = asgn_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            is_md: begin
              div_d   = is_div;
              neg_d   = is_sgn &
                        (bus.a[WIDTH-1] ^
                         bus.b[WIDTH-1]);
              asgn_d  = is_sgn & bus.a[WIDTH-1];
              mcand_d = is_div ? b_mag : a_mag;
              prod_d  = {{WIDTH{1'b0}},
                         is_div ? a_mag : b_mag};
              rem_d   = '0;
              cnt_d   = MDU_CNT_W'(MDU_ITER - 1);
              state_d = CALC;
              busy_d  = 1'b1;
            end
            is_mthi: hi_d = bus.a;
            is_mtlo: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (div_q) begin
          prod_d = {prod_q[PW-1:WIDTH],
                    prod_q[WIDTH-2:0], q_bit};
          rem_d  = q_bit ? trial[WIDTH:0]
                         : rem_sh[WIDTH:0];
        end else begin
          prod_d = {add_sum, prod_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - MDU_CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          lo_d = q_fix;
          hi_d = r_fix;
        end else begin
          hi_d = p_fix[PW-1:WIDTH];
          lo_d = p_fix[WIDTH-1:0];
        end
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      asgn_q  <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      asgn_q  <= asgn_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed + random checks of mdu_hilo
// against an arithmetic HI/LO reference model.
module tb_mdu_hilo;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mdu_hilo_if #(.WIDTH(32)) bus ();

  mdu_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int LAT = 33;

  function automatic logic [63:0] model(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin
        p = 64'(sa * sb);
        return p;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        return p;
      end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue a command now; return at the done cycle
  task automatic do_op(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output int          lat,
    output int          bcnt
  );
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    lat  = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
    hi = bus.hi;
    lo = bus.lo;
  endtask

  task automatic chk_op(
    input string       name,
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [31:0] hi, lo;
    logic [63:0] exp;
    int lat, bcnt;
    exp = model(op, a, b);
    do_op(op, a, b, hi, lo, lat, bcnt);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d",
               name, lat, LAT);
    end
    checks++;
    if (hi !== exp[63:32] || lo !== exp[31:0]) begin
      errors++;
      $display("FAIL %s hi/lo got %h/%h want %h/%h",
               name, hi, lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset got b%b d%b %h/%h want 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    int lat, bcnt;
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
          hi, lo, lat, bcnt);
    checks++;
    if (lat !== LAT || bcnt !== LAT) begin
      errors++;
      $display("FAIL multu_lat got %0d/%0d want %0d",
               lat, bcnt, LAT);
    end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h1) begin
      errors++;
      $display("FAIL multu got %h/%h want fffffffe/1",
               hi, lo);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done got %b want 0",
               bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got %b want 0",
               bus.done);
    end
    chk_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7);
    chk_op("mult_min", 3'd0, 32'h80000000,
           32'h80000000);
  endtask

  task automatic test_div();
    logic [31:0] hi, lo;
    int lat, bcnt;
    chk_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
    chk_op("divu", 3'd3, 32'd100, 32'd7);
    chk_op("div_ovf", 3'd2, 32'h80000000,
           32'hFFFFFFFF);
    chk_op("div0_s", 3'd2, 32'hFFFFFFFB, 32'd0);
    do_op(3'd3, 32'h1234, 32'd0, hi, lo, lat, bcnt);
    checks++;
    if (lat !== LAT || hi !== 32'h1234 ||
        lo !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL divu0 got %0d %h/%h want %0d %h/%h",
               lat, hi, lo, LAT, 32'h1234, 32'hFFFFFFFF);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL divu0_pulse got %b want 0",
               bus.done);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] pool [4];
    pool[0] = 32'h80000000;
    pool[1] = 32'hFFFFFFFF;
    pool[2] = 32'h00000001;
    pool[3] = 32'h7FFFFFFF;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0)
        a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0)
        b = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0)
        b = b & 32'hFF;
      chk_op($sformatf("rand%0d", i), op, a, b);
    end
  endtask

  task automatic test_mthi_mtlo();
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'hAAAA5555;
    tick();
    checks++;
    if (bus.hi !== 32'hAAAA5555 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mthi got %h b%b d%b want aaaa5555",
               bus.hi, bus.busy, bus.done);
    end
    bus.op = 3'd5;
    bus.a  = 32'h5555AAAA;
    tick();
    checks++;
    if (bus.lo !== 32'h5555AAAA ||
        bus.hi !== 32'hAAAA5555 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo got %h/%h b%b d%b",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    bus.op = 3'd6;
    bus.a  = 32'h0;
    tick();
    bus.op = 3'd7;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.hi !== 32'hAAAA5555 ||
        bus.lo !== 32'h5555AAAA ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reserved got %h/%h b%b",
               bus.hi, bus.lo, bus.busy);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b, hi0, lo0;
    logic [63:0] exp;
    int n;
    a   = $urandom;
    b   = $urandom;
    exp = model(3'd1, a, b);
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1;
    bus.op    = 3'd1;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.op = 3'd4;
    bus.a  = 32'hDEADBEEF;
    repeat (3) tick();
    bus.op = 3'd5;
    tick();
    bus.op = 3'd0;
    bus.b  = 32'd3;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.hi !== hi0 || bus.lo !== lo0 ||
        bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_hold got %h/%h b%b want %h/%h",
               bus.hi, bus.lo, bus.busy, hi0, lo0);
    end
    n = 5;
    while (bus.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LAT || bus.hi !== exp[63:32] ||
        bus.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL busy_ign got %0d %h/%h want %0d %h",
               n, bus.hi, bus.lo, LAT, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    int lat, bcnt;
    do_op(3'd0, 32'hFFFFFFF0, 32'd16,
          hi, lo, lat, bcnt);
    chk_op("b2b_2nd", 3'd2, 32'd1000, 32'hFFFFFFF9);
  endtask

  task automatic test_reset_mid();
    int dn;
    logic [31:0] hi, lo;
    int lat, bcnt;
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'h1111;
    tick();
    bus.op = 3'd1;
    bus.a  = 32'd5;
    bus.b  = 32'd6;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got b%b d%b %h/%h",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    dn = 0;
    repeat (40) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
      tick();
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d want 0",
               dn);
    end
    do_op(3'd3, 32'd9, 32'd3, hi, lo, lat, bcnt);
    checks++;
    if (lat !== LAT || hi !== 32'd0 ||
        lo !== 32'd3) begin
      errors++;
      $display("FAIL after_reset got %0d %h/%h want 0/3",
               lat, hi, lo);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with the HI/LO special registers; implements MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Sits directly downstream of the GPR file: operands come straight from the GPR read ports (souta -> a, soutb -> b).
- The control unit polls busy. It reads hi/lo for MFHI/MFLO and routes them back to the GPR write data input.

Parameters:
- WIDTH, 32, operand and HI/LO width. The design and tests cover only 32.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  command valid, sampled on a rising edge while busy=0
- op  input  3  command: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- a  input  WIDTH  operand A (rs), from GPR souta
- b  input  WIDTH  operand B (rt), from GPR soutb
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse: HI/LO hold a new MULT/DIV result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Reset takes priority over everything, including mid-operation: the operation is discarded and no result is written.
- States:
  - IDLE: wait for a command.
  - CALC: 32 iterations.
  - FIX: sign correction and HI/LO write.
- IDLE, start=1, op in 0..3:
  - Latch operand magnitudes and the operation into internal registers; set counter=31; go to CALC.
  - Magnitudes are two's-complement absolute values for op 0/2, raw values for op 1/3.
  - a and b are not required to stay stable after this edge.
- IDLE, start=1, op=4: hi<=a at that edge. Stay IDLE; busy and done stay 0.
- IDLE, start=1, op=5: lo<=a at that edge. Stay IDLE; busy and done stay 0.
- IDLE, start=1, op 6/7: no effect.
- start while busy=1: ignored for every op; it is neither queued nor an error.
- CALC, multiply: one shift-add step per cycle on a 64-bit product register.
- CALC, divide: one restoring shift-subtract step per cycle, producing one quotient bit and a partial remainder.
- CALC: the counter decrements each cycle. When counter=0, go to FIX.
- FIX:
  - Signed multiply: negate the 64-bit product if sign(a)^sign(b).
  - Signed divide: negate the quotient if sign(a)^sign(b). The remainder takes the sign of a.
  - Multiply writes hi<=product[63:32], lo<=product[31:0].
  - Divide writes lo<=quotient, hi<=remainder.
  - Go to IDLE.
- busy=1 in CALC and FIX only.
- done=1 for exactly the one cycle following the FIX edge; hi/lo carry the new values in that same cycle.
- Latency: start accepted at edge E0 -> busy=1 during cycles after E0..E33 -> hi/lo updated and done=1 after E33, busy=0.
- Result visible 33 cycles after acceptance. A new start can be accepted at E34, i.e. in the done cycle.
- HI/LO hold their values in all other cycles. They are unchanged during CALC, so they can still be read for a pending MFHI/MFLO.
- Divide by zero (b=0), signed or unsigned: lo=32'hFFFFFFFF, hi=a (original value). Same 33-cycle latency, done pulses normally.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude algorithm and needs no special case.
- Widths: product register 2*WIDTH; remainder register WIDTH+1 for the trial subtraction.

Decomposition:
- Shared package mdu_pkg holds:
  - opcode constants MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5;
  - state encoding IDLE/CALC/FIX;
  - constant MDU_ITER=32.
- Natural sub-module: mdu_sign_fix, a combinational abs/negate helper (operand magnitude in, 64-bit conditional negate out), used at both latch and FIX.
- The iteration datapath stays in mdu_hilo.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, done pulses once.
- MTHI a=0xAAAA5555 then MTLO a=0x5555AAAA on consecutive cycles -> hi/lo update the edge after each, busy/done stay 0. MTHI issued while busy -> hi unchanged and the in-flight result is correct.
- Start MULTU 5*6, assert reset at cycle 10 of CALC -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows. A new DIVU 9/3 afterwards -> lo=3, hi=0.
